voice_mixer: RTL and testbench
==============================

Name: voice_mixer

Overview:
- Sits directly downstream of the three-voice note player.
- On each codec sample request it pulses generate_next_sample to the player and captures sample_out1..3 as each voice's sample_ready fires.
- Once all active voices have reported, it sums them into one 18-bit signed sample for the codec.
- Absent or late voices contribute zero; errors are flagged sticky.

Parameters:
TIMEOUT, 64, cycles in WAIT before missing voices are forced to zero
TIMER_W, 7, width of wait timer (must hold TIMEOUT)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
codec_request  in  1  one-cycle pulse, codec needs a new sample
voice_active  in  3  bit n set = voice n+1 currently holds a note (from note player)
sample_in1  in  18  signed sample, voice 1
sample_in2  in  18  signed sample, voice 2
sample_in3  in  18  signed sample, voice 3
sample_ready1  in  1  voice 1 sample valid pulse
sample_ready2  in  1  voice 2 sample valid pulse
sample_ready3  in  1  voice 3 sample valid pulse
clear_errors  in  1  synchronous clear of sticky flags
generate_next_sample  out  1  one-cycle request pulse to note player
sample_out  out  18  mixed signed sample, held between updates
sample_valid  out  1  one-cycle pulse, sample_out updated
busy  out  1  high in any state except IDLE
overrun_err  out  1  sticky, codec_request arrived while busy
timeout_err  out  1  sticky, WAIT expired with active voices missing

Behaviour:
- Reset (async, any state, mid-operation included): state=IDLE. All outputs 0. Capture registers, got mask, active mask and timer all 0.
- States: IDLE, WAIT, SUM, OUT.
- IDLE:
  - codec_request=1: latch active_mask<=voice_active, clear got mask and captures, timer<=0, go WAIT.
  - generate_next_sample is high for exactly the one cycle following the request edge.
  - If voice_active==0, go to SUM instead; no generate_next_sample pulse.
- WAIT:
  - Each cycle, for every n with sample_readyn=1 and active_mask[n]=1: capture sample_inn and set got[n].
  - A repeat ready overwrites the capture with the latest value.
  - A ready for a voice not in active_mask is ignored. Ready pulses in IDLE, SUM or OUT are ignored.
  - got|new==active_mask: go SUM on the same edge. Simultaneous readies are all captured.
  - Otherwise timer increments. At timer==TIMEOUT-1: set timeout_err, go SUM, uncaptured voices=0.
- SUM:
  - Sign-extend the three captures to 20 bits and add; a non-captured lane is 0.
  - Scale per Optional Feature and register into sample_out. Go OUT.
- OUT: sample_valid=1 for one cycle, go IDLE.
- Latency: sample_valid is high exactly 2 cycles after the edge that captures the final ready, or the timeout edge.
- codec_request while busy: ignored (no restart), overrun_err<=1.
- clear_errors clears both sticky flags. A simultaneous set event wins.
- sample_out changes only on the SUM->OUT edge.

Optional Feature:
VOICE_MIXER_SAT_EN
- Undefined: sample_out = sum>>>2 (arithmetic). Cannot overflow; voices are attenuated by 1/4.
- Defined: sample_out = sum saturated to [-131072, 131071]. Full scale; clipping possible.

Decomposition:
- Shared include voice_mixer_defs:
  - SAMPLE_W=18, NUM_VOICES=3, ACC_W=20
  - state encodings IDLE/WAIT/SUM/OUT
  - SAT_MAX=18'sh1FFFF, SAT_MIN=18'sh20000
- Sub-module mix_capture_lane (instantiated 3×): capture register, got flag, load/clear. Parent holds the FSM, timer, adder and scaler.

Test Plan:
- voice_active=3'b111; request; readies on cycles 3/5/7 with 65536 each -> generate_next_sample one cycle after the request edge; sample_out=49152 (macro off) or 131071 (macro on); sample_valid 2 cycles after the cycle-7 edge.
- All voices -131072, simultaneous readies -> sample_out=-98304 (off) or -131072 (on); busy low afterwards.
- voice_active=3'b001, sample_in1=4000; voice 2 also pulses ready with 9999 -> voice 2 ignored; sample_out=1000 (off) or 4000 (on).
- voice_active=3'b011; only voice 1 ready (800), TIMEOUT=64 -> timeout_err=1 after 64 WAIT cycles; sample_out=200 (off) or 800 (on).
- Second codec_request during WAIT -> overrun_err=1, no second generate_next_sample pulse; clear_errors -> both flags 0.
- Reset asserted mid-WAIT -> outputs 0 immediately; next request behaves as the first test.

Source files
------------

// File: rtl/voice_mixer_pkg.sv
// rtl/voice_mixer_pkg.sv - shared widths, state encoding and output scaling for voice_mixer
// Optional feature macro: VOICE_MIXER_SAT_EN (saturating full-scale output instead of 1/4 attenuation)
package voice_mixer_pkg;

  localparam int SAMPLE_W   = 18;
  localparam int NUM_VOICES = 3;
  localparam int ACC_W      = 20;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 18'sh1FFFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 18'sh20000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SUM  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // Reduce the 20-bit three-voice sum to the 18-bit codec sample.
  function automatic logic signed [SAMPLE_W-1:0] scale_sum(input logic signed [ACC_W-1:0] acc);
`ifdef VOICE_MIXER_SAT_EN
    if (acc > ACC_W'(SAT_MAX)) begin
      return SAT_MAX;
    end else if (acc < ACC_W'(SAT_MIN)) begin
      return SAT_MIN;
    end else begin
      return acc[SAMPLE_W-1:0];
    end
`else
    // Three full-scale voices need 20 bits; dropping two LSBs always fits.
    return SAMPLE_W'(acc >>> 2);
`endif
  endfunction

endpackage

// File: rtl/mix_capture_lane.sv
// rtl/mix_capture_lane.sv - one voice's sample capture register and got flag
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   clr_i            zero the capture and got flag (start of a new mix)
//   load_i           capture din_i and set got flag (latest load wins)
//   din_i            signed voice sample
//   data_o, got_o    held capture and whether this voice has reported
module mix_capture_lane
  import voice_mixer_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr_i,
  input  logic                       load_i,
  input  logic signed [SAMPLE_W-1:0] din_i,
  output logic signed [SAMPLE_W-1:0] data_o,
  output logic                       got_o
);

  logic signed [SAMPLE_W-1:0] data_q;
  logic                       got_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      got_q  <= 1'b0;
    end else if (clr_i) begin
      data_q <= '0;
      got_q  <= 1'b0;
    end else if (load_i) begin
      data_q <= din_i;
      got_q  <= 1'b1;
    end
  end

  assign data_o = data_q;
  assign got_o  = got_q;

endmodule

// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - collects three voice samples per codec request and mixes them to one
// Optional feature macro: VOICE_MIXER_SAT_EN (see voice_mixer_pkg::scale_sum)
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   codec_request               one-cycle pulse, codec wants a new sample
//   voice_active[2:0]           voices currently holding a note
//   sample_in1..3, sample_ready1..3   per-voice sample and valid pulse
//   clear_errors                synchronous clear of sticky flags
//   generate_next_sample        one-cycle request to the note player
//   sample_out, sample_valid    mixed sample (held) and its update pulse
//   busy                        not IDLE
//   overrun_err, timeout_err    sticky error flags
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TIMER_W = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       codec_request,
  input  logic [NUM_VOICES-1:0]      voice_active,
  input  logic signed [SAMPLE_W-1:0] sample_in1,
  input  logic signed [SAMPLE_W-1:0] sample_in2,
  input  logic signed [SAMPLE_W-1:0] sample_in3,
  input  logic                       sample_ready1,
  input  logic                       sample_ready2,
  input  logic                       sample_ready3,
  input  logic                       clear_errors,
  output logic                       generate_next_sample,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic                       busy,
  output logic                       overrun_err,
  output logic                       timeout_err
);

  state_e                     state_q, state_d;
  logic [TIMER_W-1:0]         timer_q, timer_d;
  logic [NUM_VOICES-1:0]      mask_q, mask_d;
  logic                       gen_q;
  logic signed [SAMPLE_W-1:0] out_q;
  logic                       overrun_q, timeout_q;

  logic [NUM_VOICES-1:0]      ready_v, load_v, got_v;
  logic signed [SAMPLE_W-1:0] din_v [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] cap_v [NUM_VOICES];
  logic signed [ACC_W-1:0]    acc;
  logic                       start, all_in, timer_exp, overrun_set, timeout_set;

  assign ready_v  = {sample_ready3, sample_ready2, sample_ready1};
  assign din_v[0] = sample_in1;
  assign din_v[1] = sample_in2;
  assign din_v[2] = sample_in3;

  // Only voices latched as active at request time are captured, and only in WAIT.
  assign load_v    = (state_q == ST_WAIT) ? (ready_v & mask_q) : '0;
  assign start     = (state_q == ST_IDLE) && codec_request;
  // Includes this cycle's readies so completion is taken on the capturing edge.
  assign all_in    = ((got_v | load_v) == mask_q);
  assign timer_exp = (timer_q == TIMER_W'(TIMEOUT - 1));

  assign overrun_set = (state_q != ST_IDLE) && codec_request;
  assign timeout_set = (state_q == ST_WAIT) && !all_in && timer_exp;

  for (genvar n = 0; n < NUM_VOICES; n++) begin : g_lane
    mix_capture_lane u_lane (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (start),
      .load_i (load_v[n]),
      .din_i  (din_v[n]),
      .data_o (cap_v[n]),
      .got_o  (got_v[n])
    );
  end

  // Lanes that never reported contribute zero.
  always_comb begin
    acc = '0;
    for (int n = 0; n < NUM_VOICES; n++) begin
      if (got_v[n]) acc = acc + ACC_W'(cap_v[n]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      mask_q    <= '0;
      gen_q     <= 1'b0;
      out_q     <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      mask_q    <= mask_d;
      gen_q     <= start && (voice_active != '0);
      if (state_q == ST_SUM) out_q <= scale_sum(acc);
      // Set beats a simultaneous clear.
      overrun_q <= overrun_set | (overrun_q & ~clear_errors);
      timeout_q <= timeout_set | (timeout_q & ~clear_errors);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    mask_d  = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (codec_request) begin
          mask_d  = voice_active;
          timer_d = '0;
          state_d = (voice_active == '0) ? ST_SUM : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (all_in || timer_exp) begin
          state_d = ST_SUM;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_SUM:  state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != ST_IDLE);
    sample_valid = (state_q == ST_OUT);
  end

  assign generate_next_sample = gen_q;
  assign sample_out           = out_q;
  assign overrun_err          = overrun_q;
  assign timeout_err          = timeout_q;

endmodule

// File: tb/tb_voice_mixer.sv
// tb/tb_voice_mixer.sv - self-checking bench for voice_mixer
module tb_voice_mixer;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               codec_request = 1'b0;
  logic [2:0]         voice_active = '0;
  logic signed [17:0] din [3];
  logic [2:0]         rdy = '0;
  logic               clear_errors = 1'b0;
  logic               generate_next_sample;
  logic signed [17:0] sample_out;
  logic               sample_valid, busy, overrun_err, timeout_err;

  int total = 0;
  int bad = 0;

  voice_mixer dut (
    .clk                  (clk),
    .reset                (reset),
    .codec_request        (codec_request),
    .voice_active         (voice_active),
    .sample_in1           (din[0]),
    .sample_in2           (din[1]),
    .sample_in3           (din[2]),
    .sample_ready1        (rdy[0]),
    .sample_ready2        (rdy[1]),
    .sample_ready3        (rdy[2]),
    .clear_errors         (clear_errors),
    .generate_next_sample (generate_next_sample),
    .sample_out           (sample_out),
    .sample_valid         (sample_valid),
    .busy                 (busy),
    .overrun_err          (overrun_err),
    .timeout_err          (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] act;
    int c1 [3];
    int v1 [3];
    int c2 [3];
    int v2 [3];
    int e_off;
    int e_on;
    int e_lat;
    bit e_to;
  } vec_t;

  vec_t tv [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a voice's sample is the last pulse it sent up to the finishing
  // cycle; the mix finishes when every active voice has sent one, or at cycle 64.
  task automatic model(input logic [2:0] act, input int c1[3], input int v1[3],
                       input int c2[3], input int v2[3],
                       output int e_out, output int e_lat, output bit e_to);
    int fin, first, s, q;
    fin = 0;
    e_to = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if (act[n]) begin
        first = (c1[n] != 0) ? c1[n] : c2[n];
        if (first == 0 || first > 64) e_to = 1'b1;
        else if (first > fin) fin = first;
      end
    end
    if (e_to) fin = 64;
    s = 0;
    for (int n = 0; n < 3; n++) begin
      if (act[n]) begin
        if (c2[n] != 0 && c2[n] <= fin) s += v2[n];
        else if (c1[n] != 0 && c1[n] <= fin) s += v1[n];
      end
    end
`ifdef VOICE_MIXER_SAT_EN
    if (s > 131071) e_out = 131071;
    else if (s < -131072) e_out = -131072;
    else e_out = s;
`else
    q = s / 4;
    if (s < 0 && (s % 4) != 0) q = q - 1;
    e_out = q;
`endif
    e_lat = fin + 1;
  endtask

  task automatic run_txn(input string tag, input logic [2:0] act, input int c1[3], input int v1[3],
                         input int c2[3], input int v2[3],
                         input int e_out, input int e_lat, input bit e_to);
    int lat, outv, extra;
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    codec_request = 1'b1;
    voice_active = act;
    tick();
    codec_request = 1'b0;
    chk({tag, " gen_pulse"}, int'(generate_next_sample), int'(act != 3'b000));
    lat = -1;
    outv = 0;
    extra = 0;
    for (int k = 1; k <= 70 && lat < 0; k++) begin
      for (int n = 0; n < 3; n++) begin
        rdy[n] = (c1[n] == k) || (c2[n] == k);
        din[n] = (c2[n] == k) ? 18'(v2[n]) : 18'(v1[n]);
      end
      tick();
      if (generate_next_sample) extra++;
      if (sample_valid) begin
        lat = k;
        outv = int'(sample_out);
      end
    end
    rdy = '0;
    chk({tag, " latency"}, lat, e_lat);
    chk({tag, " sample_out"}, outv, e_out);
    chk({tag, " extra_gen"}, extra, 0);
    chk({tag, " timeout_err"}, int'(timeout_err), int'(e_to));
    tick();
    chk({tag, " busy_after"}, int'(busy), 0);
    chk({tag, " valid_one_cycle"}, int'(sample_valid), 0);
    chk({tag, " out_held"}, int'(sample_out), e_out);
  endtask

  initial begin
    int c1[3], v1[3], c2[3], v2[3];
    int e_out, e_lat;
    bit e_to;

    for (int n = 0; n < 3; n++) din[n] = '0;

    tv[0].act = 3'b111; tv[0].c1 = '{3, 5, 7}; tv[0].v1 = '{65536, 65536, 65536};
    tv[0].c2 = '{0, 0, 0}; tv[0].v2 = '{0, 0, 0};
    tv[0].e_off = 49152; tv[0].e_on = 131071; tv[0].e_lat = 8; tv[0].e_to = 1'b0;
    tv[1].act = 3'b111; tv[1].c1 = '{1, 1, 1}; tv[1].v1 = '{-131072, -131072, -131072};
    tv[1].c2 = '{0, 0, 0}; tv[1].v2 = '{0, 0, 0};
    tv[1].e_off = -98304; tv[1].e_on = -131072; tv[1].e_lat = 2; tv[1].e_to = 1'b0;
    tv[2].act = 3'b001; tv[2].c1 = '{2, 2, 0}; tv[2].v1 = '{4000, 9999, 0};
    tv[2].c2 = '{0, 0, 0}; tv[2].v2 = '{0, 0, 0};
    tv[2].e_off = 1000; tv[2].e_on = 4000; tv[2].e_lat = 3; tv[2].e_to = 1'b0;
    tv[3].act = 3'b011; tv[3].c1 = '{4, 0, 0}; tv[3].v1 = '{800, 0, 0};
    tv[3].c2 = '{0, 0, 0}; tv[3].v2 = '{0, 0, 0};
    tv[3].e_off = 200; tv[3].e_on = 800; tv[3].e_lat = 65; tv[3].e_to = 1'b1;
    tv[4].act = 3'b000; tv[4].c1 = '{1, 1, 1}; tv[4].v1 = '{500, 500, 500};
    tv[4].c2 = '{0, 0, 0}; tv[4].v2 = '{0, 0, 0};
    tv[4].e_off = 0; tv[4].e_on = 0; tv[4].e_lat = 1; tv[4].e_to = 1'b0;
    tv[5].act = 3'b110; tv[5].c1 = '{0, 2, 6}; tv[5].v1 = '{0, 1000, -3000};
    tv[5].c2 = '{0, 4, 0}; tv[5].v2 = '{0, 2000, 0};
    tv[5].e_off = -250; tv[5].e_on = -1000; tv[5].e_lat = 7; tv[5].e_to = 1'b0;
    tv[6].act = 3'b100; tv[6].c1 = '{0, 0, 1}; tv[6].v1 = '{0, 0, -5};
    tv[6].c2 = '{0, 0, 0}; tv[6].v2 = '{0, 0, 0};
    tv[6].e_off = -2; tv[6].e_on = -5; tv[6].e_lat = 2; tv[6].e_to = 1'b0;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset busy", int'(busy), 0);
    chk("reset gen", int'(generate_next_sample), 0);
    chk("reset sample_out", int'(sample_out), 0);
    chk("reset valid", int'(sample_valid), 0);
    chk("reset errors", int'({overrun_err, timeout_err}), 0);

    // Table vectors
    for (int i = 0; i < 7; i++) begin
`ifdef VOICE_MIXER_SAT_EN
      e_out = tv[i].e_on;
`else
      e_out = tv[i].e_off;
`endif
      run_txn($sformatf("vec%0d", i), tv[i].act, tv[i].c1, tv[i].v1, tv[i].c2, tv[i].v2,
              e_out, tv[i].e_lat, tv[i].e_to);
    end

    // Randomized transactions against the reference model
    for (int i = 0; i < 16; i++) begin
      logic [2:0] act;
      act = 3'($urandom_range(0, 7));
      for (int n = 0; n < 3; n++) begin
        c1[n] = int'($urandom_range(0, 12));
        v1[n] = int'($urandom_range(0, 262143)) - 131072;
        c2[n] = (c1[n] != 0 && $urandom_range(0, 2) == 0) ? c1[n] + int'($urandom_range(1, 4)) : 0;
        v2[n] = int'($urandom_range(0, 262143)) - 131072;
      end
      model(act, c1, v1, c2, v2, e_out, e_lat, e_to);
      run_txn($sformatf("rnd%0d", i), act, c1, v1, c2, v2, e_out, e_lat, e_to);
    end

    // Overrun during WAIT, then set-vs-clear priority
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    codec_request = 1'b1;
    voice_active = 3'b111;
    tick();
    codec_request = 1'b0;
    tick();
    tick();
    codec_request = 1'b1;
    tick();
    codec_request = 1'b0;
    chk("ovr flag", int'(overrun_err), 1);
    chk("ovr no_gen", int'(generate_next_sample), 0);
    chk("ovr still_busy", int'(busy), 1);
    rdy = 3'b111;
    for (int n = 0; n < 3; n++) din[n] = 18'sd4;
    tick();
    rdy = '0;
    chk("ovr not_valid_yet", int'(sample_valid), 0);
    tick();
    chk("ovr valid", int'(sample_valid), 1);
`ifdef VOICE_MIXER_SAT_EN
    chk("ovr sample_out", int'(sample_out), 12);
`else
    chk("ovr sample_out", int'(sample_out), 3);
`endif
    codec_request = 1'b1;
    clear_errors = 1'b1;
    tick();
    codec_request = 1'b0;
    clear_errors = 1'b0;
    chk("ovr set_beats_clear", int'(overrun_err), 1);
    chk("ovr no_restart_gen", int'(generate_next_sample), 0);
    chk("ovr no_restart_busy", int'(busy), 0);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    chk("clear overrun", int'(overrun_err), 0);
    chk("clear timeout", int'(timeout_err), 0);

    // Reset asserted mid-WAIT
    codec_request = 1'b1;
    voice_active = 3'b111;
    tick();
    codec_request = 1'b0;
    rdy = 3'b001;
    din[0] = 18'sd5;
    tick();
    rdy = '0;
    codec_request = 1'b1;
    tick();
    codec_request = 1'b0;
    chk("rst pre overrun", int'(overrun_err), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst sample_out", int'(sample_out), 0);
    chk("rst overrun", int'(overrun_err), 0);
    chk("rst valid_gen", int'({sample_valid, generate_next_sample}), 0);
    tick();
    reset = 1'b0;
    tick();
`ifdef VOICE_MIXER_SAT_EN
    e_out = tv[0].e_on;
`else
    e_out = tv[0].e_off;
`endif
    run_txn("post_reset", tv[0].act, tv[0].c1, tv[0].v1, tv[0].c2, tv[0].v2,
            e_out, tv[0].e_lat, tv[0].e_to);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
